// File: rtl/mul_issue_32bit_pkg.sv
// Shared types for the MUL issue wrapper: FSM state encoding and
// the architectural register-index width.
package mul_issue_32bit_pkg;

   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } e_mul_issue_state;

endpackage

// File: rtl/mul_issue_32bit_req_fifo.sv
// Synchronous request FIFO holding {a, b, rd}; full/empty come
// from a registered occupancy count.
module mul_req_fifo #(
   parameter int unsigned WIDTH = 69,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_q];

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = nxt(wr_q);
      if (do_pop)  rd_d = nxt(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/mul_issue_32bit.sv
// Issue wrapper between the core and the sequential multiplier:
// queues MUL ops, issues one at a time, and holds the result for writeback.
module mul_issue_32bit
   import mul_issue_32bit_pkg::*;
#(
   parameter int unsigned width          = 32,
   parameter int unsigned queue_depth    = 2,
   parameter int unsigned timeout_cycles = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] in_a,
   input  logic [width-1:0] in_b,
   input  logic [REG_W-1:0] in_rd,
   output logic             mul_req,
   output logic [width-1:0] mul_a,
   output logic [width-1:0] mul_b,
   input  logic [width-1:0] mul_out,
   input  logic             mul_ack,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [width-1:0] wb_data,
   output logic [REG_W-1:0] wb_rd,
   output logic             busy,
   output logic             err
);

   localparam int unsigned EW = 2 * width + REG_W;
   localparam int unsigned TW = $clog2(timeout_cycles + 1);

   e_mul_issue_state state_q, state_d;

   logic [width-1:0] a_q, a_d;
   logic [width-1:0] b_q, b_d;
   logic [REG_W-1:0] rd_q, rd_d;
   logic             wbv_q, wbv_d;
   logic [width-1:0] wbd_q, wbd_d;
   logic [REG_W-1:0] wbrd_q, wbrd_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             err_q, err_d;

   logic [EW-1:0]    head;
   logic [width-1:0] h_a, h_b;
   logic [REG_W-1:0] h_rd;
   logic             f_full, f_empty, f_pop;

   assign f_pop = (state_q == IDLE) && !f_empty;

   mul_req_fifo #(
      .WIDTH (EW),
      .DEPTH (queue_depth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (in_valid),
      .wdata_i ({in_a, in_b, in_rd}),
      .pop_i   (f_pop),
      .rdata_o (head),
      .full_o  (f_full),
      .empty_o (f_empty)
   );

   assign {h_a, h_b, h_rd} = head;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      rd_d    = rd_q;
      wbv_d   = wbv_q;
      wbd_d   = wbd_q;
      wbrd_d  = wbrd_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (!f_empty) begin
               if (h_rd == '0) begin
                  state_d = IDLE;
               end else if (h_a == '0 || h_b == '0) begin
                  wbd_d   = '0;
                  wbrd_d  = h_rd;
                  wbv_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  a_d     = h_a;
                  b_d     = h_b;
                  rd_d    = h_rd;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            tmo_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (mul_ack) begin
               wbd_d   = mul_out;
               wbrd_d  = rd_q;
               wbv_d   = 1'b1;
               state_d = RESP;
            end else if (tmo_q == TW'(timeout_cycles - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         RESP: begin
            if (wb_ready) begin
               wbv_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // An ack with nothing outstanding means the multiplier is out of sync.
      if (mul_ack && state_q != WAIT) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= '0;
         wbv_q   <= 1'b0;
         wbd_q   <= '0;
         wbrd_q  <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
         wbv_q   <= wbv_d;
         wbd_q   <= wbd_d;
         wbrd_q  <= wbrd_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign in_ready = !f_full;
   assign mul_req  = (state_q == ISSUE);
   assign mul_a    = a_q;
   assign mul_b    = b_q;
   assign wb_valid = wbv_q;
   assign wb_data  = wbd_q;
   assign wb_rd    = wbrd_q;
   assign busy     = !f_empty || (state_q != IDLE);
   assign err      = err_q;

endmodule

// File: tb/tb_mul_issue_32bit.sv
// Self-checking bench for mul_issue_32bit with a behavioural
// multiplier and a result scoreboard.
module tb_mul_issue_32bit;

   localparam int LAT = 17;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a, in_b;
   logic [4:0]  in_rd;
   logic        mul_req;
   logic [31:0] mul_a, mul_b, mul_out;
   logic        mul_ack;
   logic        wb_valid, wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        busy, err;

   logic        model_ack = 1'b0;
   logic [31:0] model_out = '0;
   logic        force_ack;
   logic        ack_en;
   logic        pend = 1'b0;
   int          mcnt = 0;
   logic [31:0] pa = '0, pb = '0;

   int          checks = 0;
   int          errors = 0;
   int          req_cnt = 0;
   int          exp_req = 0;
   int          rd_idx = 0;
   logic [31:0] obs_data[$];
   logic [4:0]  obs_rd[$];
   logic [31:0] exp_data[$];
   logic [4:0]  exp_rd[$];

   always #5 clk = ~clk;

   assign mul_ack = model_ack | force_ack;
   assign mul_out = model_out;

   mul_issue_32bit dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_rd    (in_rd),
      .mul_req  (mul_req),
      .mul_a    (mul_a),
      .mul_b    (mul_b),
      .mul_out  (mul_out),
      .mul_ack  (mul_ack),
      .wb_valid (wb_valid),
      .wb_ready (wb_ready),
      .wb_data  (wb_data),
      .wb_rd    (wb_rd),
      .busy     (busy),
      .err      (err)
   );

   // Behavioural multiplier: fixed latency, optional ack suppression.
   always @(posedge clk) begin
      model_ack <= 1'b0;
      if (rst) begin
         pend <= 1'b0;
      end else if (mul_req) begin
         pend <= 1'b1;
         mcnt <= LAT - 1;
         pa   <= mul_a;
         pb   <= mul_b;
      end else if (pend) begin
         if (mcnt == 0) begin
            pend <= 1'b0;
            if (ack_en) begin
               model_ack <= 1'b1;
               model_out <= pa * pb;
            end
         end else begin
            mcnt <= mcnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst && mul_req) req_cnt <= req_cnt + 1;
      if (!rst && wb_valid && wb_ready) begin
         obs_data.push_back(wb_data);
         obs_rd.push_back(wb_rd);
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
      logic [63:0] full;
      int n = 0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_rd = rd;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL push_accept in_ready=%b required=1", in_ready);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         full = {32'd0, a} * {32'd0, b};
         if (rd != 5'd0) begin
            exp_data.push_back(full[31:0]);
            exp_rd.push_back(rd);
            if (a != 0 && b != 0) exp_req++;
         end
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain(input bit rnd, input int budget);
      int n = 0;
      while ((exp_data.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         if (rnd) wb_ready = 1'($urandom_range(0, 1));
         while (rd_idx < obs_data.size()) begin
            checks++;
            if (exp_data.size() == 0) begin
               errors++;
               $display("FAIL wb_unexpected data=%h rd=%0d required=none",
                        obs_data[rd_idx], obs_rd[rd_idx]);
            end else begin
               if (obs_data[rd_idx] !== exp_data[0] ||
                   obs_rd[rd_idx] !== exp_rd[0]) begin
                  errors++;
                  $display("FAIL wb_result data=%h rd=%0d required data=%h rd=%0d",
                           obs_data[rd_idx], obs_rd[rd_idx], exp_data[0], exp_rd[0]);
               end
               void'(exp_data.pop_front());
               void'(exp_rd.pop_front());
            end
            rd_idx++;
         end
         n++;
      end
      wb_ready = 1'b1;
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout pending=%0d busy=%b required=0 0",
                  exp_data.size(), busy);
      end
   endtask

   task automatic wait_req(output bit seen);
      int n = 0;
      seen = 1'b0;
      while (!mul_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      seen = mul_req;
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_data.delete();
      exp_rd.delete();
      rd_idx = obs_data.size();
   endtask

   task automatic test_reset();
      logic [105:0] got, req;
      do_reset();
      req = {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0};
      got = {in_ready, mul_req, mul_a, mul_b, wb_valid, wb_data, wb_rd, busy, err};
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL reset_state got=%h required=%h", got, req);
      end
   endtask

   task automatic test_single();
      int r0 = req_cnt;
      bit seen;
      push(32'd7, 32'd6, 5'd3);
      wait_req(seen);
      checks++;
      if (!seen || mul_a !== 32'd7 || mul_b !== 32'd6) begin
         errors++;
         $display("FAIL single_req req=%b a=%0d b=%0d required 1 7 6",
                  seen, mul_a, mul_b);
      end
      drain(1'b0, 200);
      checks++;
      if (req_cnt - r0 !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_pulses reqs=%0d busy=%b required 1 0",
                  req_cnt - r0, busy);
      end
   endtask

   task automatic test_back_to_back();
      push(32'hFFFF_FFFF, 32'd2, 5'd1);
      push(32'h0001_0000, 32'h0001_0000, 5'd2);
      push(32'd3, 32'd5, 5'd4);
      repeat (4) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_full in_ready=%b busy=%b required 0 1",
                  in_ready, busy);
      end
      drain(1'b0, 300);
   endtask

   task automatic test_bypass();
      int r0 = req_cnt;
      int o0 = obs_data.size();
      push(32'd0, 32'd123, 5'd9);
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL bypass_early wb_valid=%b required 0", wb_valid);
      end
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== 32'd0 || wb_rd !== 5'd9) begin
         errors++;
         $display("FAIL bypass_latency v=%b d=%h rd=%0d required 1 0 9",
                  wb_valid, wb_data, wb_rd);
      end
      push(32'd5, 32'd5, 5'd0);
      repeat (6) @(negedge clk);
      checks++;
      if (req_cnt !== r0 || obs_data.size() - o0 !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bypass_x0 reqs=%0d wbs=%0d busy=%b required 0 1 0",
                  req_cnt - r0, obs_data.size() - o0, busy);
      end
      drain(1'b0, 50);
   endtask

   task automatic test_backpressure();
      int r0;
      int n = 0;
      wb_ready = 1'b0;
      push(32'd9, 32'd9, 5'd5);
      push(32'd2, 32'd3, 5'd6);
      push(32'd4, 32'd5, 5'd7);
      while (!wb_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      r0 = req_cnt;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (wb_valid !== 1'b1 || wb_data !== 32'd81 || wb_rd !== 5'd5) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d v=%b d=%0d rd=%0d required 1 81 5",
                     i, wb_valid, wb_data, wb_rd);
         end
         @(negedge clk);
      end
      checks++;
      if (req_cnt !== r0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_retain reqs=%0d in_ready=%b required 0 0",
                  req_cnt - r0, in_ready);
      end
      wb_ready = 1'b1;
      drain(1'b0, 300);
      checks++;
      if (req_cnt - r0 !== 2) begin
         errors++;
         $display("FAIL bp_resume reqs=%0d required 2", req_cnt - r0);
      end
   endtask

   task automatic test_reset_mid();
      logic [105:0] got, req;
      int o0;
      wb_ready = 1'b1;
      push(32'd3, 32'd3, 5'd1);
      push(32'd5, 32'd6, 5'd2);
      push(32'd7, 32'd8, 5'd3);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      req = {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0};
      got = {in_ready, mul_req, mul_a, mul_b, wb_valid, wb_data, wb_rd, busy, err};
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL midreset_state got=%h required=%h", got, req);
      end
      rst = 1'b0;
      exp_data.delete();
      exp_rd.delete();
      rd_idx = obs_data.size();
      o0 = obs_data.size();
      repeat (40) @(negedge clk);
      checks++;
      if (obs_data.size() !== o0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_drop wbs=%0d busy=%b required 0 0",
                  obs_data.size() - o0, busy);
      end
      push(32'd4, 32'd4, 5'd10);
      drain(1'b0, 200);
   endtask

   task automatic test_random();
      int r0 = req_cnt;
      int e0 = exp_req;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         push(a, b, 5'($urandom_range(0, 31)));
      end
      drain(1'b1, 3000);
      checks++;
      if (req_cnt - r0 !== exp_req - e0) begin
         errors++;
         $display("FAIL random_reqs got=%0d required=%0d",
                  req_cnt - r0, exp_req - e0);
      end
   endtask

   task automatic test_timeout();
      bit seen;
      int o0 = obs_data.size();
      ack_en = 1'b0;
      push(32'd2, 32'd2, 5'd4);
      void'(exp_data.pop_back());
      void'(exp_rd.pop_back());
      wait_req(seen);
      repeat (64) @(posedge clk);
      @(negedge clk);
      checks++;
      if (!seen || err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL tmo_early req=%b err=%b busy=%b required 1 0 1",
                  seen, err, busy);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL tmo_flag err=%b busy=%b required 1 0", err, busy);
      end
      repeat (30) @(negedge clk);
      checks++;
      if (obs_data.size() !== o0 || err !== 1'b1) begin
         errors++;
         $display("FAIL tmo_drop wbs=%0d err=%b required 0 1",
                  obs_data.size() - o0, err);
      end
      ack_en = 1'b1;
      do_reset();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL tmo_clear err=%b required 0", err);
      end
   endtask

   task automatic test_spurious();
      logic [104:0] got, req;
      @(negedge clk);
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      req = {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0};
      got = {in_ready, mul_req, mul_a, mul_b, wb_valid, wb_data, wb_rd, busy};
      checks++;
      if (err !== 1'b1 || got !== req) begin
         errors++;
         $display("FAIL spurious_ack err=%b outs=%h required 1 %h",
                  err, got, req);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_rd = '0;
      wb_ready = 1'b1;
      ack_en = 1'b1;
      force_ack = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_bypass();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_timeout();
      test_spurious();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
